ro_meas_ctrl: RTL and testbench



---
 rtl/ro_meas_pkg.sv | 15 +
 rtl/ro_meas_ctrl_if.sv | 28 ++
 rtl/sync_edge_det.sv | 26 ++
 rtl/ro_meas_ctrl.sv | 112 +++++++++++
 tb/tb_ro_meas_ctrl.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/ro_meas_pkg.sv
// Shared types and default sizing for the ring-oscillator measurement sequencer.
package ro_meas_pkg;

  localparam int CNT_W_DEF      = 16;
  localparam int WIN_W_DEF      = 16;
  localparam int SETTLE_CYC_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_COUNT  = 2'd2,
    ST_DONE   = 2'd3
  } ro_state_e;

endpackage

// File: rtl/ro_meas_ctrl_if.sv
// Request/result bundle between the measurement sequencer and the readout logic.
interface ro_meas_ctrl_if
  import ro_meas_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int WIN_W = WIN_W_DEF
);
  logic             START;
  logic [WIN_W-1:0] WIN_LEN;
  logic             BUSY;
  logic             VALID;
  logic             ACK;
  logic [CNT_W-1:0] COUNT;
  logic             OVF;

  // START is taken only while idle (BUSY=0, VALID=0). VALID rises once the
  // window closes and stays high with COUNT/OVF frozen until ACK is seen;
  // the transfer completes on the edge where VALID and ACK are both high.
  modport master (
    output START, WIN_LEN, ACK,
    input  BUSY, VALID, COUNT, OVF
  );

  modport slave (
    input  START, WIN_LEN, ACK,
    output BUSY, VALID, COUNT, OVF
  );
endinterface

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous clock-like input, followed by a
// one-flop rising-edge detector producing a single-cycle pulse.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);
  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= async_in;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;
endmodule

// File: rtl/ro_meas_ctrl.sv
// Ring-oscillator measurement sequencer: enable, settle, count synchronized
// oscillator edges over a programmable window, then hold the result for readout.
module ro_meas_ctrl
  import ro_meas_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int WIN_W      = WIN_W_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          RO_IN,
  output logic          RO_EN,
  ro_meas_ctrl_if.slave bus,
  output ro_state_e     dbg_state
);
  // One down-counter serves both the settle delay and the window.
  localparam int DN_W = (WIN_W > $clog2(SETTLE_CYC + 1)) ? WIN_W : $clog2(SETTLE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [DN_W-1:0]  SETTLE_LOAD = DN_W'(SETTLE_CYC - 1);

  ro_state_e        state_q, state_d;
  logic [DN_W-1:0]  dn_q, dn_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             ro_en_q, ro_en_d;
  logic             ro_edge;

  sync_edge_det u_sync (
    .clk      (CLK),
    .rst      (RESET),
    .async_in (RO_IN),
    .rise     (ro_edge)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      dn_q    <= '0;
      win_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      ro_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dn_q    <= dn_d;
      win_q   <= win_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      ro_en_q <= ro_en_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dn_d    = dn_q;
    win_d   = win_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    ro_en_d = ro_en_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.START) begin
          state_d = ST_SETTLE;
          win_d   = bus.WIN_LEN;
          count_d = '0;
          ovf_d   = 1'b0;
          dn_d    = SETTLE_LOAD;
          ro_en_d = 1'b1;
        end
      end
      ST_SETTLE: begin
        // Edges seen here are from the oscillator starting up and are dropped.
        if (dn_q == '0) begin
          if (win_q == '0) begin
            state_d = ST_DONE;
            ro_en_d = 1'b0;
          end else begin
            state_d = ST_COUNT;
            dn_d    = DN_W'(win_q) - DN_W'(1);
          end
        end else begin
          dn_d = dn_q - DN_W'(1);
        end
      end
      ST_COUNT: begin
        if (ro_edge) begin
          if (count_q == CNT_MAX) ovf_d = 1'b1;
          else                    count_d = count_q + CNT_W'(1);
        end
        if (dn_q == '0) begin
          state_d = ST_DONE;
          ro_en_d = 1'b0;
        end else begin
          dn_d = dn_q - DN_W'(1);
        end
      end
      ST_DONE: begin
        if (bus.ACK) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign RO_EN     = ro_en_q;
  assign bus.BUSY  = (state_q == ST_SETTLE) || (state_q == ST_COUNT);
  assign bus.VALID = (state_q == ST_DONE);
  assign bus.COUNT = count_q;
  assign bus.OVF   = ovf_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_ro_meas_ctrl.sv
// Directed bench for ro_meas_ctrl with a 4-bit counter so saturation is reachable.
module tb_ro_meas_ctrl;
  import ro_meas_pkg::*;

  logic      CLK = 1'b0;
  logic      RESET;
  logic      ro_in = 1'b0;
  logic      ro_en;
  ro_state_e dbg_state;
  int        ro_half = 0;
  int        ro_ph = 0;
  int        n_tests = 0;
  int        n_fail = 0;

  ro_meas_ctrl_if #(.CNT_W(4), .WIN_W(16)) bus ();

  ro_meas_ctrl #(.CNT_W(4), .WIN_W(16), .SETTLE_CYC(8)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .RO_IN     (ro_in),
    .RO_EN     (ro_en),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 CLK = ~CLK;

  // Oscillator model: square wave with ro_half CLK periods per phase, 0 when off.
  always @(negedge CLK) begin
    if (ro_half == 0) begin
      ro_in = 1'b0;
      ro_ph = 0;
    end else begin
      ro_ph++;
      if (ro_ph >= ro_half) begin
        ro_ph = 0;
        ro_in = ~ro_in;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] win;
    int          h;
    int          stop;
    int          en;
    int          va;
    int          cnt;
    int          ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Accepts one measurement and runs until VALID (or the cycle budget expires).
  task automatic measure(input logic [15:0] win, input int h, input int stop_at,
                         output int en_cyc, output int valid_at,
                         output logic [31:0] cnt0, output int busy_bad);
    bus.WIN_LEN = win;
    bus.START   = 1'b1;
    step();
    bus.START   = 1'b0;
    bus.WIN_LEN = ~win;
    ro_half     = h;
    en_cyc      = 0;
    valid_at    = 0;
    busy_bad    = 0;
    cnt0        = 32'(bus.COUNT);
    for (int c = 1; c <= 400; c++) begin
      if (stop_at != 0 && c == stop_at) ro_half = 0;
      if (bus.BUSY !== ro_en) busy_bad++;
      if (bus.VALID === 1'b1) begin
        valid_at = c;
        break;
      end
      if (ro_en === 1'b1) en_cyc++;
      step();
    end
  endtask

  task automatic ack_result(input int exp_cnt);
    bus.ACK = 1'b1;
    step();
    bus.ACK = 1'b0;
    check("ack_valid_low", 32'(bus.VALID), 0);
    check("ack_idle", 32'(dbg_state), 32'(ST_IDLE));
    check("ack_ro_en_low", 32'(ro_en), 0);
    check("ack_count_kept", 32'(bus.COUNT), 32'(exp_cnt));
    repeat (4) step();
  endtask

  initial begin
    int          en_cyc, valid_at, busy_bad;
    logic [31:0] cnt0;

    vecs[0] = '{win: 16'd100, h: 5, stop: 0, en: 108, va: 109, cnt: 10, ovf: 0};
    vecs[1] = '{win: 16'd0,   h: 0, stop: 0, en: 8,   va: 9,   cnt: 0,  ovf: 0};
    vecs[2] = '{win: 16'd200, h: 2, stop: 0, en: 208, va: 209, cnt: 15, ovf: 1};
    vecs[3] = '{win: 16'd1,   h: 0, stop: 0, en: 9,   va: 10,  cnt: 0,  ovf: 0};
    vecs[4] = '{win: 16'd20,  h: 5, stop: 0, en: 28,  va: 29,  cnt: 2,  ovf: 0};
    vecs[5] = '{win: 16'd50,  h: 2, stop: 9, en: 58,  va: 59,  cnt: 0,  ovf: 0};
    vecs[6] = '{win: 16'd60,  h: 2, stop: 0, en: 68,  va: 69,  cnt: 15, ovf: 0};
    vecs[7] = '{win: 16'd64,  h: 2, stop: 0, en: 72,  va: 73,  cnt: 15, ovf: 1};

    RESET       = 1'b1;
    bus.START   = 1'b0;
    bus.ACK     = 1'b0;
    bus.WIN_LEN = '0;
    repeat (2) step();
    check("rst_ro_en", 32'(ro_en), 0);
    check("rst_busy", 32'(bus.BUSY), 0);
    check("rst_valid", 32'(bus.VALID), 0);
    check("rst_count", 32'(bus.COUNT), 0);
    check("rst_ovf", 32'(bus.OVF), 0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    RESET = 1'b0;
    repeat (3) step();
    check("idle_no_start", 32'(dbg_state), 32'(ST_IDLE));

    foreach (vecs[i]) begin
      measure(vecs[i].win, vecs[i].h, vecs[i].stop, en_cyc, valid_at, cnt0, busy_bad);
      ro_half = 0;
      check($sformatf("v%0d_en_cycles", i), 32'(en_cyc), 32'(vecs[i].en));
      check($sformatf("v%0d_valid_at", i), 32'(valid_at), 32'(vecs[i].va));
      check($sformatf("v%0d_count_cleared", i), cnt0, 0);
      check($sformatf("v%0d_busy_eq_en", i), 32'(busy_bad), 0);
      check($sformatf("v%0d_count", i), 32'(bus.COUNT), 32'(vecs[i].cnt));
      check($sformatf("v%0d_ovf", i), 32'(bus.OVF), 32'(vecs[i].ovf));
      check($sformatf("v%0d_ro_en_off", i), 32'(ro_en), 0);
      repeat (3) step();
      check($sformatf("v%0d_valid_hold", i), 32'(bus.VALID), 1);
      check($sformatf("v%0d_count_hold", i), 32'(bus.COUNT), 32'(vecs[i].cnt));
      ack_result(vecs[i].cnt);
    end

    // START/ACK arriving while busy, and START together with ACK in DONE.
    bus.WIN_LEN = 16'd20;
    bus.START   = 1'b1;
    step();
    bus.START   = 1'b0;
    bus.WIN_LEN = 16'd7;
    ro_half     = 5;
    en_cyc      = 0;
    valid_at    = 0;
    for (int c = 1; c <= 400; c++) begin
      if (bus.VALID === 1'b1) begin
        valid_at = c;
        break;
      end
      if (ro_en === 1'b1) en_cyc++;
      case (c)
        3:  bus.START = 1'b1;
        4:  bus.START = 1'b0;
        15: begin bus.START = 1'b1; bus.ACK = 1'b1; end
        16: begin bus.START = 1'b0; bus.ACK = 1'b0; end
        default: ;
      endcase
      step();
    end
    ro_half = 0;
    check("busy_en_cycles", 32'(en_cyc), 28);
    check("busy_valid_at", 32'(valid_at), 29);
    check("busy_count", 32'(bus.COUNT), 2);
    bus.START = 1'b1;
    bus.ACK   = 1'b1;
    step();
    bus.START = 1'b0;
    bus.ACK   = 1'b0;
    check("start_ack_valid", 32'(bus.VALID), 0);
    check("start_ack_idle", 32'(dbg_state), 32'(ST_IDLE));
    check("start_ack_ro_en", 32'(ro_en), 0);
    check("start_ack_count", 32'(bus.COUNT), 2);
    step();
    check("start_ack_still_idle", 32'(dbg_state), 32'(ST_IDLE));
    check("start_ack_not_busy", 32'(bus.BUSY), 0);
    repeat (3) step();
    measure(16'd0, 0, 0, en_cyc, valid_at, cnt0, busy_bad);
    check("fresh_count_cleared", cnt0, 0);
    check("fresh_en_cycles", 32'(en_cyc), 8);
    check("fresh_valid_at", 32'(valid_at), 9);
    ack_result(0);

    // Asynchronous reset in the middle of the window, at COUNT=5.
    bus.WIN_LEN = 16'd100;
    bus.START   = 1'b1;
    step();
    bus.START   = 1'b0;
    ro_half     = 2;
    repeat (28) step();
    check("mid_count5", 32'(bus.COUNT), 5);
    check("mid_state_count", 32'(dbg_state), 32'(ST_COUNT));
    RESET = 1'b1;
    #1;
    check("mid_rst_ro_en", 32'(ro_en), 0);
    check("mid_rst_busy", 32'(bus.BUSY), 0);
    check("mid_rst_valid", 32'(bus.VALID), 0);
    check("mid_rst_count", 32'(bus.COUNT), 0);
    check("mid_rst_ovf", 32'(bus.OVF), 0);
    check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    ro_half = 0;
    repeat (2) step();
    RESET = 1'b0;
    repeat (4) step();
    measure(16'd20, 5, 0, en_cyc, valid_at, cnt0, busy_bad);
    ro_half = 0;
    check("post_rst_en_cycles", 32'(en_cyc), 28);
    check("post_rst_valid_at", 32'(valid_at), 29);
    check("post_rst_count", 32'(bus.COUNT), 2);
    check("post_rst_ovf", 32'(bus.OVF), 0);
    ack_result(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
